bram_skew_feeder: RTL and testbench
===================================

# bram_skew_feeder

Sits directly downstream of the UART-to-BRAM loader and reads both 4x4 operand matrices out of the two dual-port BRAMs (A and B) on their read ports. It holds them in local register files and streams them into the left and top edges of the Booth systolic array. The stream uses the diagonal skew that output-stationary accumulation requires: row r is delayed r cycles and column c is delayed c cycles. It replaces the ad-hoc free-running read loop with a start/done handshake.

## Interface
- N, 4, matrix dimension (array is N x N; BRAM depth N*N)
- DATA_W, 8, element width
- ADDR_W, 4, BRAM address width; must satisfy 2**ADDR_W >= N*N
- RD_LAT, 1, BRAM read latency in cycles (1 or 2 supported)
- clk  input  1  system clock (same clock as the BRAM read ports); one clock only
- reset  input  1  asynchronous, active-low reset
- i_start  input  1  request one load+stream run; sampled only in IDLE
- o_addr_a  output  ADDR_W  BRAM A read address
- o_addr_b  output  ADDR_W  BRAM B read address
- i_data_a  input  DATA_W  BRAM A read data
- i_data_b  input  DATA_W  BRAM B read data
- o_row_data  output  N*DATA_W  left-edge operands; slice r = bits [r*DATA_W +: DATA_W]
- o_row_valid  output  N  per-row operand valid
- o_col_data  output  N*DATA_W  top-edge operands; slice c as above
- o_col_valid  output  N  per-column operand valid
- o_busy  output  1  high in LOAD and STREAM
- o_done  output  1  one-cycle pulse at end of run

## Operation
- Memory layout: BRAM A addr r*N+k holds A[r][k]; BRAM B addr k*N+c holds B[k][c]. Both are row-major.
- States: IDLE, LOAD, STREAM, DONE.
- IDLE: i_start=1 moves to LOAD; address counter cleared.
- LOAD: issues addresses 0..N*N-1 on o_addr_a and o_addr_b, both identical, one per cycle. Data is captured RD_LAT cycles after each address into local regs a_reg[addr] and b_reg[addr]. A delayed address/valid pipe of depth RD_LAT selects the write index. LOAD lasts N*N+RD_LAT cycles, then moves to STREAM with t=0.
- Outside the address-issue cycles, o_addr_a and o_addr_b are 0.
- STREAM: t counts 0..2N-2, one cycle each. Outputs are registered and reflect the current t.
  - row r: if 0 <= t-r < N, data = A[r][t-r] and valid=1; else data=0 and valid=0.
  - col c: if 0 <= t-c < N, data = B[t-c][c] and valid=1; else data=0 and valid=0.
  - After t=2N-2, moves to DONE.
- DONE: one cycle; o_done=1, all data and valid outputs 0, o_busy=0; then returns to IDLE.
- i_start is ignored in LOAD, STREAM and DONE. No queuing.
- Arithmetic: t is $clog2(2N-1) bits wide. The t-r comparison is done unsigned after guarding t >= r, so there is no negative wrap.
- reset=0 at any time, including mid-LOAD or mid-STREAM: state goes to IDLE immediately. All outputs and counters go to 0; local regs are cleared to 0. A partially loaded matrix is never streamed.

## Timing
- Reset values: o_addr_a=o_addr_b=0, o_row_data=o_col_data=0, o_row_valid=o_col_valid=0, o_busy=0, o_done=0.
- Cycle numbering: i_start is high in IDLE in cycle 0.
- LOAD occupies cycles 1..N*N+RD_LAT. Address k is presented in cycle 1+k. Data for address k is captured at the end of cycle 1+k+RD_LAT.
- STREAM occupies cycles N*N+RD_LAT+1 .. N*N+RD_LAT+2N-1. For N=4, RD_LAT=1: cycles 18..24.
- DONE is in cycle N*N+RD_LAT+2N (25 for defaults). IDLE resumes the following cycle; a new i_start is accepted from then on.
- o_busy is high exactly during LOAD and STREAM and low during DONE.
- Each array edge sees N consecutive valid operands per lane. Lane r's first valid is r cycles after lane 0's.

## Test plan
- Reset: hold reset=0 with random i_data -> every output is 0. Release, with i_start=0 for 10 cycles -> outputs stay 0 and o_busy=0.
- Default run with A[r][k]=4r+k+1 and B[k][c]=16+4k+c+1, start in cycle 0:
  - addresses 0..15 appear in cycles 1..16;
  - cycle 18: row0=1, col0=17, valid 0001;
  - cycle 21: rows = {1:4, 2:7, 3:10, 4:13} -> row0..3 = 4, 7, 10, 13; cols = 29, 26, 23, 20; valid 1111;
  - cycle 24: only row3=16 and col3=32 valid;
  - o_done=1 in cycle 25.
- Start while busy: pulse i_start in cycles 5 and 20 -> no effect and timing unchanged. Start in cycle 27 -> new run, LOAD begins cycle 28.
- Reset mid-STREAM: assert reset=0 in cycle 21 -> outputs 0 in the same cycle with no o_done. Release and restart with new data -> only new values are streamed.
- RD_LAT=2, same data: LOAD spans cycles 1..18 and STREAM spans cycles 19..25. The cycle-22 operands match the default-run cycle-21 values; o_done=1 in cycle 26.
- i_start held high continuously: runs repeat back-to-back with exactly one IDLE cycle between DONE and the next LOAD.

Source files
------------

// File: rtl/bram_skew_feeder.sv
// Loads two NxN operand matrices from BRAM read ports into local registers, then
// streams them diagonally skewed into the left/top edges of an output-stationary systolic array.
module bram_skew_feeder #(
    parameter int unsigned N      = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_start,
    output logic [ADDR_W-1:0]     o_addr_a,
    output logic [ADDR_W-1:0]     o_addr_b,
    input  logic [DATA_W-1:0]     i_data_a,
    input  logic [DATA_W-1:0]     i_data_b,
    output logic [N*DATA_W-1:0]   o_row_data,
    output logic [N-1:0]          o_row_valid,
    output logic [N*DATA_W-1:0]   o_col_data,
    output logic [N-1:0]          o_col_valid,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int unsigned NN       = N * N;
    localparam int unsigned IW       = (NN > 1) ? $clog2(NN) : 1;
    localparam int unsigned TW       = (N > 1) ? $clog2(2 * N - 1) : 1;
    localparam int unsigned LOAD_CYC = NN + RD_LAT;
    localparam int unsigned LW       = $clog2(LOAD_CYC + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STREAM,
        ST_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [LW-1:0]       lcnt_q, lcnt_d;
    logic [TW-1:0]       t_q, t_d;

    logic                addr_vld_d, addr_vld_q;
    logic [ADDR_W-1:0]   addr_d;
    logic [RD_LAT-1:0]   vld_pipe;
    logic [IW-1:0]       idx_pipe [RD_LAT];

    logic [DATA_W-1:0]   a_reg [NN];
    logic [DATA_W-1:0]   b_reg [NN];

    logic [N*DATA_W-1:0] row_data_d, col_data_d;
    logic [N-1:0]        row_valid_d, col_valid_d;

    // State and run counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            lcnt_q  <= '0;
            t_q     <= '0;
        end else begin
            state_q <= state_d;
            lcnt_q  <= lcnt_d;
            t_q     <= t_d;
        end
    end

    // Next state, next counters, and the values the output registers will take
    always_comb begin
        state_d     = state_q;
        lcnt_d      = lcnt_q;
        t_d         = t_q;
        addr_vld_d  = 1'b0;
        addr_d      = '0;
        row_data_d  = '0;
        row_valid_d = '0;
        col_data_d  = '0;
        col_valid_d = '0;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_LOAD;
                    lcnt_d  = '0;
                end
            end
            ST_LOAD: begin
                if (lcnt_q == LW'(LOAD_CYC - 1)) begin
                    state_d = ST_STREAM;
                    t_d     = '0;
                end else begin
                    lcnt_d = lcnt_q + LW'(1);
                end
            end
            ST_STREAM: begin
                if (t_q == TW'(2 * N - 2)) begin
                    state_d = ST_DONE;
                end else begin
                    t_d = t_q + TW'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        addr_vld_d = (state_d == ST_LOAD) && (lcnt_d < LW'(NN));
        addr_d     = addr_vld_d ? ADDR_W'(lcnt_d) : '0;

        // Diagonal skew: lane i carries element (t - i) once t has reached i
        if (state_d == ST_STREAM) begin
            for (int unsigned i = 0; i < N; i++) begin
                if ((t_d >= TW'(i)) && ((t_d - TW'(i)) < TW'(N))) begin
                    row_valid_d[i] = 1'b1;
                    col_valid_d[i] = 1'b1;
                    row_data_d[i*DATA_W +: DATA_W] =
                        a_reg[IW'(i * N) + IW'(t_d - TW'(i))];
                    col_data_d[i*DATA_W +: DATA_W] =
                        b_reg[IW'(IW'(t_d - TW'(i)) * IW'(N)) + IW'(i)];
                end
            end
        end
    end

    // Registered outputs and the read-latency matching pipe
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_addr_a    <= '0;
            o_addr_b    <= '0;
            addr_vld_q  <= 1'b0;
            vld_pipe    <= '0;
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                idx_pipe[i] <= '0;
            end
            o_row_data  <= '0;
            o_row_valid <= '0;
            o_col_data  <= '0;
            o_col_valid <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            o_addr_a    <= addr_d;
            o_addr_b    <= addr_d;
            addr_vld_q  <= addr_vld_d;
            vld_pipe[0] <= addr_vld_q;
            idx_pipe[0] <= IW'(o_addr_a);
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                idx_pipe[i] <= idx_pipe[i-1];
            end
            o_row_data  <= row_data_d;
            o_row_valid <= row_valid_d;
            o_col_data  <= col_data_d;
            o_col_valid <= col_valid_d;
            o_busy      <= (state_d == ST_LOAD) || (state_d == ST_STREAM);
            o_done      <= (state_d == ST_DONE);
        end
    end

    // Local operand stores; cleared on reset so a partial load is never visible
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NN; i++) begin
                a_reg[i] <= '0;
                b_reg[i] <= '0;
            end
        end else if (vld_pipe[RD_LAT-1]) begin
            a_reg[idx_pipe[RD_LAT-1]] <= i_data_a;
            b_reg[idx_pipe[RD_LAT-1]] <= i_data_b;
        end
    end

endmodule

// File: tb/tb_bram_skew_feeder.sv
// Scoreboard bench for bram_skew_feeder: two instances (RD_LAT=1 and RD_LAT=2) share stimulus
// and BRAM contents; a reference model pushes expected stream beats, a monitor pops and compares.
module tb_bram_skew_feeder;

    localparam int N      = 4;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int NN     = N * N;
    localparam int W      = N * DATA_W;

    typedef struct {
        int           cyc;
        logic [W-1:0] rd;
        logic [N-1:0] rv;
        logic [W-1:0] cd;
        logic [N-1:0] cv;
        logic         done;
    } beat_t;

    logic clk     = 1'b0;
    logic reset   = 1'b0;
    logic i_start = 1'b0;
    logic [DATA_W-1:0] noise_a = '0;
    logic [DATA_W-1:0] noise_b = '0;
    logic [DATA_W-1:0] mem_a [NN];
    logic [DATA_W-1:0] mem_b [NN];

    logic [ADDR_W-1:0] addr_a [2];
    logic [ADDR_W-1:0] addr_b [2];
    logic [W-1:0]      row_data [2];
    logic [W-1:0]      col_data [2];
    logic [N-1:0]      row_valid [2];
    logic [N-1:0]      col_valid [2];
    logic              busy [2];
    logic              done [2];

    int cyc        = 0;
    int n_checks   = 0;
    int n_fail     = 0;
    int s [2]      = '{-1000, -1000};
    int next_ok [2] = '{0, 0};
    logic drain_req  = 1'b0;
    logic drain_done = 1'b0;
    beat_t q0 [$];
    beat_t q1 [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [DATA_W-1:0] r1a, r2a, r1b, r2b;
        logic [DATA_W-1:0] da, db;
        // BRAM read port with latency g+1
        always @(posedge clk) begin
            r1a <= mem_a[addr_a[g]];
            r1b <= mem_b[addr_b[g]];
            r2a <= r1a;
            r2b <= r1b;
        end
        assign da = ((g == 0) ? r1a : r2a) ^ noise_a;
        assign db = ((g == 0) ? r1b : r2b) ^ noise_b;

        bram_skew_feeder #(
            .N(N), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(g + 1)
        ) u_dut (
            .clk        (clk),
            .reset      (reset),
            .i_start    (i_start),
            .o_addr_a   (addr_a[g]),
            .o_addr_b   (addr_b[g]),
            .i_data_a   (da),
            .i_data_b   (db),
            .o_row_data (row_data[g]),
            .o_row_valid(row_valid[g]),
            .o_col_data (col_data[g]),
            .o_col_valid(col_valid[g]),
            .o_busy     (busy[g]),
            .o_done     (done[g])
        );
    end

    function automatic int qsz(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic beat_t qhead(input int d);
        return (d == 0) ? q0[0] : q1[0];
    endfunction

    task automatic qpop(input int d);
        if (d == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
    endtask

    task automatic qpush(input int d, input beat_t b);
        if (d == 0) q0.push_back(b);
        else        q1.push_back(b);
    endtask

    task automatic chk(input string name, input int d, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d (RD_LAT=%0d) cycle %0d: got %0h, expected %0h",
                     name, d, d + 1, cyc, got, exp);
        end
    endtask

    // Expected stream of one run: A[r][t-r] on rows, B[t-c][c] on columns, then a done beat
    task automatic push_run(input int d, input int s0);
        beat_t b;
        int    st;
        st = s0 + NN + (d + 1) + 1;
        for (int t = 0; t <= 2 * N - 2; t++) begin
            b.cyc = st + t; b.rd = '0; b.rv = '0; b.cd = '0; b.cv = '0; b.done = 1'b0;
            for (int r = 0; r < N; r++) begin
                if (t - r >= 0 && t - r < N) begin
                    b.rv[r] = 1'b1;
                    b.cv[r] = 1'b1;
                    b.rd[r*DATA_W +: DATA_W] = mem_a[r * N + (t - r)];
                    b.cd[r*DATA_W +: DATA_W] = mem_b[(t - r) * N + r];
                end
            end
            qpush(d, b);
        end
        b.cyc = st + 2 * N - 1; b.rd = '0; b.rv = '0; b.cd = '0; b.cv = '0; b.done = 1'b1;
        qpush(d, b);
    endtask

    // Reference model: accepts a start only once the previous run has returned to idle
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q0.delete();
            q1.delete();
            for (int d = 0; d < 2; d++) begin
                s[d]       = -1000;
                next_ok[d] = 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (i_start && cyc >= next_ok[d]) begin
                    s[d]       = cyc;
                    next_ok[d] = cyc + NN + (d + 1) + 2 * N + 1;
                    push_run(d, cyc);
                end
            end
        end
    end

    int    m_kk, m_len, m_ea;
    logic  m_act, m_due;
    beat_t m_b;

    // Monitor: timeline checks on busy/address, scoreboard pops on any output activity
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            m_kk  = cyc - s[d] - 1;
            m_len = NN + (d + 1) + 2 * N - 1;
            m_ea  = (m_kk >= 0 && m_kk < NN) ? m_kk : 0;
            chk("busy", d, 64'(busy[d]), 64'((m_kk >= 0 && m_kk < m_len) ? 1 : 0));
            chk("addr_a", d, 64'(addr_a[d]), 64'(m_ea));
            chk("addr_b", d, 64'(addr_b[d]), 64'(m_ea));
            m_act = (row_valid[d] != '0) || (col_valid[d] != '0) || done[d];
            m_due = 1'b0;
            if (qsz(d) > 0) begin
                m_b   = qhead(d);
                m_due = (m_b.cyc <= cyc);
            end
            if (m_act || m_due) begin
                if (qsz(d) == 0) begin
                    chk("unexpected_output", d, 64'({row_valid[d], col_valid[d], done[d]}), 64'(0));
                end else begin
                    qpop(d);
                    chk("beat_cycle", d, 64'(cyc), 64'(m_b.cyc));
                    chk("row_valid", d, 64'(row_valid[d]), 64'(m_b.rv));
                    chk("row_data", d, 64'(row_data[d]), 64'(m_b.rd));
                    chk("col_valid", d, 64'(col_valid[d]), 64'(m_b.cv));
                    chk("col_data", d, 64'(col_data[d]), 64'(m_b.cd));
                    chk("done", d, 64'(done[d]), 64'(m_b.done));
                end
            end else begin
                chk("idle_data", d, 64'({row_data[d], col_data[d]}), 64'(0));
            end
        end
        if (drain_req && !drain_done) begin
            for (int d = 0; d < 2; d++) chk("queue_drained", d, 64'(qsz(d)), 64'(0));
            drain_done = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 200 && (cyc < next_ok[0] || cyc < next_ok[1]); k++) step();
    endtask

    task automatic rand_mem();
        for (int i = 0; i < NN; i++) begin
            mem_a[i] = DATA_W'($urandom);
            mem_b[i] = DATA_W'($urandom);
        end
    endtask

    initial begin
        rand_mem();
        // Reset held with noisy read data, then quiet idle
        repeat (6) begin
            step();
            noise_a = DATA_W'($urandom);
            noise_b = DATA_W'($urandom);
        end
        noise_a = '0;
        noise_b = '0;
        reset   = 1'b1;
        idle(10);

        // Default run, with starts while busy (5, 20) and a restart at 27
        for (int i = 0; i < NN; i++) begin
            mem_a[i] = DATA_W'(i + 1);
            mem_b[i] = DATA_W'(i + 17);
        end
        i_start = 1'b1;
        for (int rel = 1; rel <= 60; rel++) begin
            step();
            i_start = (rel == 5 || rel == 20 || rel == 27);
        end

        // Reset in cycle 21 of a run, then a run with fresh data
        i_start = 1'b1;
        for (int rel = 1; rel <= 21; rel++) begin
            step();
            i_start = 1'b0;
        end
        reset = 1'b0;
        idle(3);
        rand_mem();
        reset   = 1'b1;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        idle(40);

        // Random data, random gaps, random start noise during LOAD
        for (int it = 0; it < 8; it++) begin
            wait_idle();
            rand_mem();
            repeat ($urandom_range(0, 3)) step();
            i_start = 1'b1;
            step();
            repeat (4) begin
                i_start = 1'($urandom);
                step();
            end
            i_start = 1'b0;
        end
        wait_idle();

        // Start held high: back-to-back runs
        rand_mem();
        i_start = 1'b1;
        idle(90);
        i_start = 1'b0;
        idle(60);

        drain_req = 1'b1;
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
